bcd_score_tracker: RTL and testbench

BCD_SCORE_TRACKER -- requirements
Module: bcd_score_tracker

---
 rtl/score_pkg.sv | 36 +++
 rtl/seg7_bcd.sv | 30 +++
 rtl/bcd_score_tracker.sv | 157 +++++++++++++++
 tb/tb_bcd_score_tracker.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score tracker: game states,
// seven-segment patterns (bit 0 = a ... bit 6 = g) and a decimal-to-BCD helper.
package score_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    WIN  = 2'd1,
    LOSE = 2'd2
  } state_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Elaboration-time conversion of a decimal constant into four packed BCD digits.
  function automatic logic [15:0] toBcd(input int value);
    logic [15:0] result;
    int          rest;
    result = '0;
    rest   = value;
    for (int i = 0; i < 4; i++) begin
      result[4*i +: 4] = 4'(rest % 10);
      rest             = rest / 10;
    end
    return result;
  endfunction

endpackage

// File: rtl/seg7_bcd.sv
// Single-digit BCD to active-high seven-segment decoder with a blank override;
// codes 10..15 decode to blank.
module seg7_bcd
  import score_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_score_tracker.sv
// Snake-style game score tracker: BCD score, PLAY/WIN/LOSE states, blinking LOSE display.
// Define HISCORE_EN to keep the best finished-game score in hiscore_bcd.
module bcd_score_tracker
  import score_pkg::*;
#(
  parameter int DIGITS    = 2,
  parameter int WIN_SCORE = 50,
  parameter int BLINK_DIV = 50
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                good_coll,
  input  logic                bad_coll,
  input  logic                restart,
  input  logic                disp_en,
  output logic [4*DIGITS-1:0] score_bcd,
  output logic [4*DIGITS-1:0] hiscore_bcd,
  output logic [7*DIGITS-1:0] seg,
  output logic                game_complete,
  output logic                win
);

  localparam int             W           = 4 * DIGITS;
  localparam int             CW          = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [15:0]    WIN_BCD_ALL = toBcd(WIN_SCORE);
  localparam logic [W-1:0]   WIN_BCD     = WIN_BCD_ALL[W-1:0];
  localparam logic [CW-1:0]  BLINK_LAST  = CW'(BLINK_DIV - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  score_q, score_d;
  logic [CW-1:0] blinkCnt_q, blinkCnt_d;
  logic          blinkHidden_q, blinkHidden_d;
  logic          goodPrev_q, badPrev_q;
  logic          goodEvent, badEvent;

  function automatic logic [W-1:0] bcdInc(input logic [W-1:0] value);
    logic [W-1:0] result;
    logic         carry;
    result = value;
    carry  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (result[4*i +: 4] == 4'd9) begin
          result[4*i +: 4] = 4'd0;
        end else begin
          result[4*i +: 4] = result[4*i +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
    return result;
  endfunction

  assign goodEvent = good_coll & ~goodPrev_q;
  assign badEvent  = bad_coll  & ~badPrev_q;

  // Restart dominates; bad beats good; the blink counter only runs in LOSE.
  always_comb begin
    state_d       = state_q;
    score_d       = score_q;
    blinkCnt_d    = blinkCnt_q;
    blinkHidden_d = blinkHidden_q;
    if (restart) begin
      state_d       = PLAY;
      score_d       = '0;
      blinkCnt_d    = '0;
      blinkHidden_d = 1'b0;
    end else begin
      case (state_q)
        PLAY: begin
          if (badEvent) begin
            state_d = LOSE;
          end else if (goodEvent) begin
            score_d = bcdInc(score_q);
            if (score_d == WIN_BCD) state_d = WIN;
          end
        end
        LOSE: begin
          if (blinkCnt_q == BLINK_LAST) begin
            blinkCnt_d    = '0;
            blinkHidden_d = ~blinkHidden_q;
          end else begin
            blinkCnt_d = blinkCnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= PLAY;
      score_q       <= '0;
      blinkCnt_q    <= '0;
      blinkHidden_q <= 1'b0;
      goodPrev_q    <= 1'b0;
      badPrev_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      score_q       <= score_d;
      blinkCnt_q    <= blinkCnt_d;
      blinkHidden_q <= blinkHidden_d;
      goodPrev_q    <= good_coll;
      badPrev_q     <= bad_coll;
    end
  end

`ifdef HISCORE_EN
  logic [W-1:0] hiscore_q, hiscore_d;

  // The final score of a game is captured as it leaves PLAY, including a winning increment.
  always_comb begin
    hiscore_d = hiscore_q;
    if (!restart && state_q == PLAY && state_d != PLAY && score_d > hiscore_q)
      hiscore_d = score_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hiscore_q <= '0;
    else       hiscore_q <= hiscore_d;
  end

  assign hiscore_bcd = hiscore_q;
`else
  assign hiscore_bcd = '0;
`endif

  assign score_bcd     = score_q;
  assign game_complete = (state_q != PLAY);
  assign win           = (state_q == WIN);

  logic          blankAll;
  logic          zeroRun;
  logic [DIGITS-1:0] lzBlank;

  assign blankAll = ~disp_en | ((state_q == LOSE) & blinkHidden_q);

  // Leading-zero suppression walks down from the top digit; digit 0 is never suppressed.
  always_comb begin
    lzBlank = '0;
    zeroRun = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zeroRun    = zeroRun & (score_q[4*i +: 4] == 4'd0);
      lzBlank[i] = zeroRun;
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : gDigit
    seg7_bcd uDigit (
      .bcd_i  (score_q[4*i +: 4]),
      .blank_i(blankAll | lzBlank[i]),
      .seg_o  (seg[7*i +: 7])
    );
  end

endmodule

// File: tb/tb_bcd_score_tracker.sv
// Directed testbench for bcd_score_tracker (DIGITS=2, WIN_SCORE=50, BLINK_DIV=4);
// expected hiscore depends on whether HISCORE_EN is defined.
module tb_bcd_score_tracker;

  localparam int DIGITS    = 2;
  localparam int WIN_SCORE = 50;
  localparam int BLINK_DIV = 4;

  logic        clk;
  logic        reset;
  logic        good_coll;
  logic        bad_coll;
  logic        restart;
  logic        disp_en;
  logic [7:0]  score_bcd;
  logic [7:0]  hiscore_bcd;
  logic [13:0] seg;
  logic        game_complete;
  logic        win;

  int checkCount = 0;
  int errorCount = 0;

  bcd_score_tracker #(
    .DIGITS   (DIGITS),
    .WIN_SCORE(WIN_SCORE),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .good_coll    (good_coll),
    .bad_coll     (bad_coll),
    .restart      (restart),
    .disp_en      (disp_en),
    .score_bcd    (score_bcd),
    .hiscore_bcd  (hiscore_bcd),
    .seg          (seg),
    .game_complete(game_complete),
    .win          (win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge: drive inputs, let one rising edge pass, return at the next falling edge.
  task automatic applyStimulus(input logic g, input logic b, input logic r);
    good_coll = g;
    bad_coll  = b;
    restart   = r;
    @(negedge clk);
  endtask

  task automatic pulseGood(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
  endtask

  logic [7:0] expHiscore;
  logic [13:0] expSeg;

  initial begin
`ifdef HISCORE_EN
    expHiscore = 8'h09;
`else
    expHiscore = 8'h00;
`endif
    reset     = 1'b1;
    good_coll = 1'b0;
    bad_coll  = 1'b0;
    restart   = 1'b0;
    disp_en   = 1'b1;
    #12;
    checkOutput("rst_score", score_bcd, 8'h00);
    checkOutput("rst_hiscore", hiscore_bcd, 8'h00);
    checkOutput("rst_seg", seg, 14'h003F);
    checkOutput("rst_complete", game_complete, 1'b0);
    checkOutput("rst_win", win, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    pulseGood(10);
    checkOutput("score10", score_bcd, 8'h10);
    checkOutput("seg10", seg, {7'h06, 7'h3F});
    pulseGood(2);
    checkOutput("score12", score_bcd, 8'h12);
    checkOutput("seg12", seg, {7'h06, 7'h5B});
    checkOutput("complete12", game_complete, 1'b0);

    disp_en = 1'b0;
    #1;
    checkOutput("disp_off_seg", seg, 14'h0000);
    checkOutput("disp_off_score", score_bcd, 8'h12);
    disp_en = 1'b1;
    @(negedge clk);

    pulseGood(37);
    checkOutput("score49", score_bcd, 8'h49);
    checkOutput("win49", win, 1'b0);
    pulseGood(1);
    checkOutput("score50", score_bcd, 8'h50);
    checkOutput("win50", win, 1'b1);
    checkOutput("complete50", game_complete, 1'b1);
    pulseGood(1);
    checkOutput("score51", score_bcd, 8'h50);

    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("restart_score", score_bcd, 8'h00);
    checkOutput("restart_win", win, 1'b0);
    checkOutput("restart_complete", game_complete, 1'b0);

    pulseGood(7);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("both_score", score_bcd, 8'h07);
    checkOutput("both_complete", game_complete, 1'b1);
    checkOutput("both_win", win, 1'b0);
    checkOutput("blink_k0", seg, 14'h0007);
    for (int k = 1; k <= 2 * BLINK_DIV; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      expSeg = (((k / BLINK_DIV) % 2) == 0) ? 14'h0007 : 14'h0000;
      checkOutput($sformatf("blink_k%0d", k), seg, expSeg);
    end
    pulseGood(1);
    checkOutput("lose_ignores_good", score_bcd, 8'h07);
    for (int k = 2 * BLINK_DIV + 2; k < 3 * BLINK_DIV; k++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("blink_hidden", seg, 14'h0000);

    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_score", score_bcd, 8'h00);
    checkOutput("async_complete", game_complete, 1'b0);
    checkOutput("async_win", win, 1'b0);
    checkOutput("async_seg", seg, 14'h003F);
    checkOutput("async_hiscore", hiscore_bcd, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    pulseGood(9);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("lose9_score", score_bcd, 8'h09);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    pulseGood(4);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("lose4_complete", game_complete, 1'b1);
    checkOutput("hiscore_after_lose4", hiscore_bcd, expHiscore);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("hiscore_after_restart", hiscore_bcd, expHiscore);

    pulseGood(3);
    checkOutput("score3", score_bcd, 8'h03);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("restart_good_score", score_bcd, 8'h00);
    checkOutput("restart_good_complete", game_complete, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("held_after_restart", score_bcd, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("held_one_increment", score_bcd, 8'h01);

    reset     = 1'b1;
    good_coll = 1'b1;
    #1;
    checkOutput("held_rst_score", score_bcd, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    checkOutput("held_across_reset", score_bcd, 8'h01);
    good_coll = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
